// File: rtl/mem_port_arbiter8.sv
// Round-robin arbiter/sequencer for one shared 8-input resource. It grants one requester
// at a time, holds the grant until completion, and a watchdog releases stalled grants.
module mem_port_arbiter8 #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       resp,
    input  logic       err_clr,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_grant, w_grant_nxt;
    logic [2:0]    r_sel,   w_sel_nxt;
    logic [2:0]    r_ptr,   w_ptr_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_err,   w_err_nxt;

    logic [14:0]   w_req_dbl;
    logic [7:0]    w_req_rot;
    logic [2:0]    w_off;
    logic [2:0]    w_win;
    logic          w_timeout;
    logic          w_release;

    // Rotate req so bit 0 is the highest-priority requester; the winner is the
    // lowest set bit of the rotated vector, offset back by ptr (wrap is free in 3 bits).
    always_comb begin
        w_req_dbl = {req[6:0], req};
        w_req_rot = w_req_dbl[r_ptr +: 8];
        w_off     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_req_rot[k]) w_off = 3'(k);
        end
        w_win = r_ptr + w_off;
    end

    assign w_timeout = (r_cnt == CNT_LAST);
    assign w_release = resp | ~req[r_sel] | w_timeout;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err & ~err_clr;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = 8'b1 << w_win;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 8'h00;
                    w_ptr_nxt   = r_sel + 3'd1;
                    // Completion and abort outrank the watchdog; a new timeout beats err_clr.
                    if (!resp && req[r_sel]) w_err_nxt = 1'b1;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 8'h00;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign grant       = r_grant;
    assign sel         = r_sel;
    assign busy        = (r_state == S_BUSY);
    assign timeout_err = r_err;

endmodule

// File: tb/tb_mem_port_arbiter8.sv
// Scoreboard bench for mem_port_arbiter8: stimulus queues expected grants, a negedge
// monitor pops them and checks grant, sel, hold length, idle gap and error flag.
module tb_mem_port_arbiter8;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       resp;
    logic       err_clr;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout_err;

    mem_port_arbiter8 #(.TIMEOUT(4), .CW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .resp        (resp),
        .err_clr     (err_clr),
        .grant       (grant),
        .sel         (sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // len = 0 skips the hold-length check; gap < 0 skips the idle-gap check.
    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        int         len;
        logic       err;
        int         gap;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   m_len    = 0;
    int   m_idle   = 0;
    logic m_busy_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expect_txn(input logic [7:0] g, input logic [2:0] s,
                                       input int len, input logic err, input int gap);
        exp_t e;
        e.grant = g;
        e.sel   = s;
        e.len   = len;
        e.err   = err;
        e.gap   = gap;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (busy && !m_busy_q) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(grant), 32'h0);
            end else begin
                cur = sb.pop_front();
                check("grant", 32'(grant), 32'(cur.grant));
                check("sel", 32'(sel), 32'(cur.sel));
                if (cur.gap >= 0) check("idle_gap", 32'(m_idle), 32'(cur.gap));
            end
            m_len = 1;
        end else if (busy) begin
            m_len++;
            check("grant_hold", 32'(grant), 32'(cur.grant));
        end else if (m_busy_q) begin
            if (cur.len > 0) check("grant_len", 32'(m_len), 32'(cur.len));
            check("err_at_release", 32'(timeout_err), 32'(cur.err));
            m_idle = 1;
        end else begin
            m_idle++;
        end
        m_busy_q = busy;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20 && !busy; i++) cycle();
        check("grant_seen", 32'(busy), 32'h1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) cycle();
        check("release_seen", 32'(busy), 32'h0);
    endtask

    // Holds the grant for len cycles by pulsing resp, then applies req_after.
    task automatic do_txn(input int len, input logic [7:0] req_after);
        wait_busy();
        repeat (len - 1) cycle();
        resp = 1'b1;
        cycle();
        resp = 1'b0;
        req  = req_after;
    endtask

    initial begin
        reset   = 1'b1;
        req     = 8'hFF;
        resp    = 1'b0;
        err_clr = 1'b0;
        #12;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(timeout_err), 32'h0);
        cycle();
        reset = 1'b0;

        // All eight requesting: order 0..7 then back to 0, one idle cycle between grants.
        for (int i = 0; i < 9; i++) begin
            expect_txn(8'(1 << (i % 8)), 3'(i % 8), 1, 1'b0, (i == 0) ? -1 : 1);
        end
        for (int i = 0; i < 9; i++) do_txn(1, (i == 8) ? 8'h00 : 8'hFF);

        // Single requester 5 held 3 cycles; next round must wrap past 6, 7 to 0.
        req = 8'h20;
        expect_txn(8'h20, 3'd5, 3, 1'b0, -1);
        expect_txn(8'h01, 3'd0, 1, 1'b0, 1);
        do_txn(3, 8'h21);
        do_txn(1, 8'h00);

        // Watchdog: no resp, release after 4 cycles with a sticky error.
        req = 8'h08;
        expect_txn(8'h08, 3'd3, 4, 1'b1, -1);
        wait_busy();
        wait_idle();
        req = 8'h00;
        check("timeout_err_set", 32'(timeout_err), 32'h1);
        cycle();
        check("timeout_err_sticky", 32'(timeout_err), 32'h1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("timeout_err_clr", 32'(timeout_err), 32'h0);

        // resp on the expiry cycle is a normal completion.
        req = 8'h08;
        expect_txn(8'h08, 3'd3, 4, 1'b0, -1);
        do_txn(4, 8'h00);
        check("resp_at_timeout_err", 32'(timeout_err), 32'h0);

        // Requester 2 aborts while 6 waits; 6's request is ignored during the grant.
        req = 8'h04;
        expect_txn(8'h04, 3'd2, 2, 1'b0, -1);
        wait_busy();
        req = 8'h44;
        cycle();
        req = 8'h40;
        expect_txn(8'h40, 3'd6, 1, 1'b0, 1);
        cycle();
        check("abort_grant", 32'(grant), 32'h0);
        check("abort_err", 32'(timeout_err), 32'h0);
        do_txn(1, 8'h00);

        // Asynchronous reset mid-grant clears outputs immediately and resets ptr.
        req = 8'hFF;
        expect_txn(8'h80, 3'd7, 0, 1'b0, -1);
        wait_busy();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'h0);
        check("async_rst_sel", 32'(sel), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        expect_txn(8'h01, 3'd0, 1, 1'b0, -1);
        #2;
        reset = 1'b0;
        do_txn(1, 8'h00);

        // resp while idle has no effect.
        resp = 1'b1;
        cycle();
        resp = 1'b0;
        cycle();
        check("idle_resp_busy", 32'(busy), 32'h0);
        check("idle_resp_grant", 32'(grant), 32'h0);

        repeat (3) cycle();
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

endmodule

// File: doc/mem_port_arbiter8.md
Name: mem_port_arbiter8

Overview:
- Round-robin arbiter and sequencer for one shared 8-input datapath resource, such as the physical-memory or writeback port.
- Accepts up to 8 request lines and grants exactly one at a time.
- Drives the 3-bit select of the downstream 8:1 data mux and holds the grant until the resource signals completion.
- Includes a watchdog that forcibly releases a stalled grant and flags an error.

Parameters:
- TIMEOUT, 255, number of BUSY cycles without resp before forced release (1..2^CW-1).
- CW, 8, width of the watchdog counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request lines, bit i = requester i; level-sensitive.
- resp  input  1  resource completion strobe for the current grant, one cycle.
- err_clr  input  1  synchronous clear of timeout_err.
- grant  output  8  one-hot grant, registered; all zero when idle.
- sel  output  3  encoded index of the granted requester, feeds the mux select.
- busy  output  1  high while in BUSY.
- timeout_err  output  1  sticky watchdog error flag.

Behaviour:
- Reset (async, immediate, including mid-grant):
  - State = IDLE; grant = 0; sel = 0; busy = 0; timeout_err = 0.
  - Priority pointer ptr = 0; watchdog count = 0.
- States: IDLE, BUSY. All outputs are registered; there are no combinational paths from req to grant.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise, at the next rising edge, choose winner w = first asserted bit scanning ptr, ptr+1, ..., wrapping 7 -> 0.
  - On that edge: grant = 1 << w; sel = w; busy = 1; count = 0; state goes to BUSY.
  - Latency: req asserted before edge N gives grant visible after edge N.
- BUSY:
  - grant and sel are held stable. req changes on other bits are ignored.
  - count increments each cycle, saturating.
  - Exits, checked in priority order:
    1. resp == 1: at the edge, grant = 0; busy = 0; ptr = (w+1) mod 8; go to IDLE.
    2. req[w] == 0 (requester abort): same release as resp; no error.
    3. count == TIMEOUT-1 with no resp: release as above, and set timeout_err = 1.
- Simultaneous events:
  - resp coinciding with the timeout edge counts as a normal completion; timeout_err is not set.
  - resp received while in IDLE is ignored.
- Back-to-back: after a release edge at least one IDLE cycle follows. The next grant appears on the following edge, so the minimum grant-to-grant gap is 1 idle cycle.
- Fairness:
  - Round-robin applies: the last winner has lowest priority next round.
  - With all 8 requesting continuously, the grant order is 0, 1, 2, ..., 7, 0.
  - Wrap from 7 to 0 requires no special case.
- sel:
  - Retains the last winner's value in IDLE, so the mux output is stable but don't-care.
  - Changes only on a grant edge.
- timeout_err:
  - Cleared by reset, or by err_clr at the next edge.
  - If err_clr coincides with a new timeout, set wins.
- Invariants:
  - grant is zero or one-hot.
  - busy == (grant != 0).
  - sel == index of grant whenever busy.
- Counter width: TIMEOUT must fit in CW bits. The count does not wrap; it saturates at its maximum.

Test Plan:
- Reset with req=8'hFF held, then deassert reset -> first edge: grant=8'h01, sel=0, busy=1. Pulse resp each transaction -> grants proceed 01, 02, 04, ... 80, then 01, with one idle cycle between each.
- Single requester req=8'h20, resp pulsed 3 cycles after grant -> grant=8'h20, sel=5 for exactly 3 cycles; busy then drops; ptr=6. Next req=8'h21 -> grant=8'h01 (0 is found first after the 6, 7 wrap).
- TIMEOUT=4, req=8'h08, resp never asserted -> grant=8'h08 for 4 cycles, then released with timeout_err=1. Pulse err_clr -> timeout_err=0 next cycle.
- TIMEOUT=4, resp on the same cycle as timeout expiry -> release with timeout_err stays 0.
- Grant held for req[2]; drop req[2] mid-transaction while req[6] is high -> grant=0 next edge, no error, then grant=8'h40.
- Assert reset asynchronously mid-BUSY (between edges) -> grant, busy, and sel go to 0 immediately without a clock edge. After release, arbitration restarts at ptr=0.
